// File: rtl/torpedo_ctrl.sv
// Torpedo launcher: fire FSM with cooldown, per-slot lifetime counters,
// lowest-free-slot allocation and hit clearing.
// Optional feature: define TORPEDO_AUTOFIRE_EN so a held button refires
// after every cooldown; otherwise each press fires once.
module torpedo_ctrl #(
  parameter int unsigned T_NUM           = 4,
  parameter int unsigned LIFE_FRAMES     = 60,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         frame_tick,
  input  logic                                         fire_btn,
  input  logic                                         hit_valid,
  input  logic [((T_NUM > 1) ? $clog2(T_NUM) : 1)-1:0] hit_idx,
  output logic                                         launch_valid,
  output logic [((T_NUM > 1) ? $clog2(T_NUM) : 1)-1:0] launch_idx,
  output logic [T_NUM-1:0]                             active,
  output logic [1:0]                                   state
);

  localparam int unsigned IW = (T_NUM > 1) ? $clog2(T_NUM) : 1;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    READY        = 2'd0,
    COOLDOWN     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_launch;
  logic            w_has_free;
  logic [IW-1:0]   w_free_idx;
  logic [T_NUM-1:0] w_hit_mask;
  logic [T_NUM-1:0] w_expire;
  logic [CW-1:0]   r_cool;
  logic [CW-1:0]   r_life [T_NUM];
  logic [T_NUM-1:0] r_active;
  logic            r_launch_valid;
  logic [IW-1:0]   r_launch_idx;

  assign launch_valid = r_launch_valid;
  assign launch_idx   = r_launch_idx;
  assign active       = r_active;
  assign state        = r_state;

  // Lowest-index free slot, taken from the registered mask only
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = int'(T_NUM) - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  // Per-slot hit decode and lifetime expiry; out-of-range indices match nothing
  always_comb begin
    w_hit_mask = '0;
    w_expire   = '0;
    for (int i = 0; i < int'(T_NUM); i++) begin
      w_hit_mask[i] = hit_valid && (32'(hit_idx) == 32'(i)) && r_active[i];
      w_expire[i]   = frame_tick && r_active[i] && (r_life[i] == CW'(1));
    end
  end

  // Fire FSM next state and launch decision
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      READY: begin
        if (fire_btn && w_has_free) begin
          w_launch    = 1'b1;
          w_state_nxt = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (frame_tick && (r_cool == CW'(1))) begin
`ifdef TORPEDO_AUTOFIRE_EN
          w_state_nxt = READY;
`else
          w_state_nxt = fire_btn ? WAIT_RELEASE : READY;
`endif
        end
      end
      WAIT_RELEASE: begin
        if (!fire_btn) w_state_nxt = READY;
      end
      default: w_state_nxt = READY;
    endcase
  end

  // FSM state, cooldown counter and launch outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= READY;
      r_cool         <= '0;
      r_launch_valid <= 1'b0;
      r_launch_idx   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_launch_valid <= w_launch;
      if (w_launch) begin
        r_launch_idx <= w_free_idx;
        r_cool       <= CW'(COOLDOWN_FRAMES);
      end else if (frame_tick && (r_cool != '0)) begin
        r_cool <= r_cool - CW'(1);
      end
    end
  end

  // Slot occupancy and lifetime counters; launch load wins over a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= '0;
      for (int i = 0; i < int'(T_NUM); i++) r_life[i] <= '0;
    end else begin
      for (int i = 0; i < int'(T_NUM); i++) begin
        if (w_launch && (w_free_idx == IW'(i))) begin
          r_active[i] <= 1'b1;
          r_life[i]   <= CW'(LIFE_FRAMES);
        end else if (w_hit_mask[i] || w_expire[i]) begin
          r_active[i] <= 1'b0;
          r_life[i]   <= '0;
        end else if (frame_tick && (r_life[i] != '0)) begin
          r_life[i] <= r_life[i] - CW'(1);
        end
      end
    end
  end

endmodule
